// File: rtl/online_pkg.sv
// Shared definitions for the online arithmetic chain: borrow-save digit rail
// encodings, the converter state type and the rail-to-digit decoder.
package online_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  // Decoded digit values, two's complement in two bits.
  localparam logic [1:0] DIG_P1 = 2'b01;
  localparam logic [1:0] DIG_Z  = 2'b00;
  localparam logic [1:0] DIG_N1 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  // Both rails high cancel to zero, same as both low.
  function automatic logic [1:0] sd_decode(input logic plus, input logic minus);
    logic [1:0] dig;
    case ({plus, minus})
      SD_POS:  dig = DIG_P1;
      SD_NEG:  dig = DIG_N1;
      default: dig = DIG_Z;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/otf_qqm_step.sv
// One on-the-fly conversion step: picks the shifted next Q/QM pair for a
// decoded signed digit, keeping QM = Q - 1 without a carry chain.
module otf_qqm_step
  import online_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] qm_i,
  input  logic [1:0]   digit_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] qm_o
);

  always_comb begin
    q_o  = {q_i[W-2:0], 1'b0};
    qm_o = {qm_i[W-2:0], 1'b1};
    case (digit_i)
      DIG_P1: begin
        q_o  = {q_i[W-2:0], 1'b1};
        qm_o = {q_i[W-2:0], 1'b0};
      end
      DIG_N1: begin
        q_o  = {qm_i[W-2:0], 1'b1};
        qm_o = {qm_i[W-2:0], 1'b0};
      end
      default: begin
        q_o  = {q_i[W-2:0], 1'b0};
        qm_o = {qm_i[W-2:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/otf_sd_converter.sv
// MSD-first borrow-save to two's complement converter, one digit per cycle,
// with a start/convert/hold handshake and a registered result.
module otf_sd_converter
  import online_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         d_valid,
  input  logic                         d_plus,
  input  logic                         d_minus,
  output logic                         d_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         result_valid,
  output logic [DIGITS:0]              result,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

  localparam int W  = DIGITS + 1;
  localparam int CW = $clog2(DIGITS + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   q_q, q_d, qm_q, qm_d;
  logic [W-1:0]   q_step, qm_step;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;
  logic           done_q, done_d;
  logic           rvalid_q, rvalid_d;

  otf_qqm_step #(.W(W)) u_step (
    .q_i     (q_q),
    .qm_i    (qm_q),
    .digit_i (sd_decode(d_plus, d_minus)),
    .q_o     (q_step),
    .qm_o    (qm_step)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    qm_d     = qm_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    rvalid_d = rvalid_q;
    // start outranks any digit in every state, including an abort mid-run.
    if (start) begin
      state_d  = ST_CONVERT;
      q_d      = '0;
      qm_d     = '1;
      cnt_d    = '0;
      rvalid_d = 1'b0;
    end else if (state_q == ST_CONVERT && d_valid) begin
      q_d   = q_step;
      qm_d  = qm_step;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DIGITS - 1)) begin
        result_d = q_step;
        done_d   = 1'b1;
        rvalid_d = 1'b1;
        state_d  = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      qm_q     <= '1;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      qm_q     <= qm_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign d_ready      = (state_q == ST_CONVERT);
  assign busy         = (state_q == ST_CONVERT);
  assign done         = done_q;
  assign result_valid = rvalid_q;
  assign result       = result_q;
  assign digit_cnt    = cnt_q;

endmodule

// File: tb/tb_otf_sd_converter.sv
// Self-checking bench for otf_sd_converter with DIGITS=4: directed cases plus
// random digit streams against an integer weighted-sum reference.
module tb_otf_sd_converter;

  localparam int DIGITS = 4;
  localparam int W      = DIGITS + 1;
  localparam int CW     = $clog2(DIGITS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          d_valid = 1'b0;
  logic          d_plus = 1'b0;
  logic          d_minus = 1'b0;
  logic          d_ready, busy, done, result_valid;
  logic [W-1:0]  result;
  logic [CW-1:0] digit_cnt;

  int vectors = 0;
  int miscompares = 0;
  int digs[4];
  logic [W-1:0] last_exp;

  otf_sd_converter #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .d_valid      (d_valid),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .d_ready      (d_ready),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .result       (result),
    .digit_cnt    (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rails(input int d, input int idx);
    if (d > 0)      begin d_plus = 1'b1; d_minus = 1'b0; end
    else if (d < 0) begin d_plus = 1'b0; d_minus = 1'b1; end
    else if (idx % 2 == 0) begin d_plus = 1'b1; d_minus = 1'b1; end
    else            begin d_plus = 1'b0; d_minus = 1'b0; end
  endtask

  // Reference: value = sum d_i * 2^(DIGITS-1-i), truncated to W bits.
  function automatic logic [W-1:0] ref_value();
    int v = 0;
    for (int i = 0; i < DIGITS; i++) v = v * 2 + digs[i];
    return W'(v);
  endfunction

  task automatic convert(input string name, input bit do_start, input int maxgap);
    logic [W-1:0] exp;
    int gap;
    exp = ref_value();
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check({name, " start busy"}, 32'(busy), 32'd1);
      check({name, " start rvalid"}, 32'(result_valid), 32'd0);
    end
    check({name, " start cnt"}, 32'(digit_cnt), 32'd0);
    for (int i = 0; i < DIGITS; i++) begin
      gap = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
      d_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check({name, " gap cnt"}, 32'(digit_cnt), 32'(i));
        check({name, " gap done"}, 32'(done), 32'd0);
      end
      d_valid = 1'b1;
      set_rails(digs[i], i);
      tick();
      d_valid = 1'b0;
      if (i < DIGITS - 1) begin
        check({name, " cnt"}, 32'(digit_cnt), 32'(i + 1));
        check({name, " early done"}, 32'(done), 32'd0);
      end
    end
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " rvalid"}, 32'(result_valid), 32'd1);
    check({name, " result"}, 32'(result), 32'(exp));
    check({name, " busy after"}, 32'(busy), 32'd0);
    tick();
    check({name, " done pulse"}, 32'(done), 32'd0);
    check({name, " result hold"}, 32'(result), 32'(exp));
    last_exp = exp;
    $display("conv %s digits %0d %0d %0d %0d -> result %b expected %b",
             name, digs[0], digs[1], digs[2], digs[3], result, exp);
  endtask

  initial begin
    tick();
    tick();
    check("reset result", 32'(result), 32'd0);
    check("reset rvalid", 32'(result_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ready", 32'(d_ready), 32'd0);
    check("reset cnt", 32'(digit_cnt), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    // IDLE ignores digits.
    d_valid = 1'b1; d_plus = 1'b1; d_minus = 1'b0;
    tick(); tick();
    d_valid = 1'b0;
    check("idle cnt", 32'(digit_cnt), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    digs = '{1, 0, -1, 1};   convert("dir7", 1'b1, 0);
    digs = '{-1, 0, 0, 0};   convert("dirm8", 1'b1, 0);
    digs = '{1, -1, -1, -1}; convert("dir1", 1'b1, 0);
    digs = '{0, 0, 0, 0};    convert("dirzero", 1'b1, 0);
    digs = '{1, 1, 1, 1};    convert("gaps15", 1'b1, 3);

    // Abort after two digits; the digit presented with start is dropped.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_valid = 1'b1; set_rails(1, i); tick();
    end
    start = 1'b1; d_valid = 1'b1; set_rails(1, 0);
    tick();
    start = 1'b0; d_valid = 1'b0;
    check("abort cnt", 32'(digit_cnt), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort busy", 32'(busy), 32'd1);
    digs = '{-1, -1, -1, -1}; convert("abortm15", 1'b0, 0);

    // HOLD ignores digits, then restarts cleanly.
    for (int c = 0; c < 5; c++) begin
      d_valid = 1'b1;
      set_rails(int'($urandom_range(2, 0)) - 1, c);
      tick();
      check("hold result", 32'(result), 32'(last_exp));
      check("hold ready", 32'(d_ready), 32'd0);
      check("hold cnt", 32'(digit_cnt), 32'(DIGITS));
    end
    d_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("restart rvalid", 32'(result_valid), 32'd0);
    check("restart busy", 32'(busy), 32'd1);
    digs = '{1, 1, -1, 0}; convert("restart", 1'b0, 1);

    // Reset mid-conversion with a digit present.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_valid = 1'b1; set_rails(-1, i); tick();
    end
    reset = 1'b1; d_valid = 1'b1; set_rails(1, 1);
    tick();
    reset = 1'b0;
    check("midrst result", 32'(result), 32'd0);
    check("midrst rvalid", 32'(result_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ready", 32'(d_ready), 32'd0);
    check("midrst cnt", 32'(digit_cnt), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    tick(); tick();
    d_valid = 1'b0;
    check("postrst cnt", 32'(digit_cnt), 32'd0);
    check("postrst rvalid", 32'(result_valid), 32'd0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < DIGITS; i++) digs[i] = int'($urandom_range(2, 0)) - 1;
      convert("rand", 1'b1, (n % 2 == 0) ? 0 : 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
